// File: rtl/sim_run_pkg.sv
// Shared state/reason encodings for the simulation run controller.
package sim_run_pkg;

  localparam int STATE_W  = 2;
  localparam int REASON_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } run_state_e;

  typedef enum logic [REASON_W-1:0] {
    RSN_NONE    = 3'd0,
    RSN_HALT    = 3'd1,
    RSN_TIMEOUT = 3'd2,
    RSN_MON_ERR = 3'd3,
    RSN_MEM_ERR = 3'd4,
    RSN_STALL   = 3'd5
  } reason_e;

endpackage

// File: rtl/commit_popcount.sv
// Combinational population count of the per-channel commit strobes.
module commit_popcount #(
  parameter int CHANNELS = 8,
  parameter int POP_W    = $clog2(CHANNELS + 1)
) (
  input  logic [CHANNELS-1:0] commit,
  output logic [POP_W-1:0]    count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      count = count + POP_W'(commit[i]);
    end
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: RUN -> (DRAIN) -> DONE with cycle/commit accounting.
// Optional stall watchdog compiled in with RUN_CTRL_STALL_WDOG_EN.
module sim_run_ctrl
  import sim_run_pkg::*;
#(
  parameter int          CHANNELS     = 8,
  parameter int          CNT_W        = 64,
  parameter int unsigned DRAIN_CYCLES = 5,
  parameter int unsigned STALL_LIMIT  = 100000
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [CHANNELS-1:0]                           halt,
  input  logic [CHANNELS-1:0]                           commit,
  input  logic                                          mon_error,
  input  logic                                          mem_error,
  input  logic [CNT_W-1:0]                              timeout_cycles,
  output logic [STATE_W-1:0]                            state,
  output logic                                          finish,
  output logic                                          fail,
  output logic [REASON_W-1:0]                           reason,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] halt_chan,
  output logic [CNT_W-1:0]                              cycle_count,
  output logic [CNT_W-1:0]                              commit_count
);

  localparam int HC_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int POP_W   = $clog2(CHANNELS + 1);
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD =
    (DRAIN_CYCLES > 0) ? DRAIN_W'(DRAIN_CYCLES - 1) : '0;

  run_state_e         state_q, state_d;
  reason_e            reason_q, reason_d, win;
  logic               finish_q, finish_d;
  logic               fail_q, fail_d;
  logic [HC_W-1:0]    halt_chan_q, halt_chan_d, halt_low;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]   cycle_count_q, commit_count_q;
  logic [POP_W-1:0]   pop;
  logic               armed_q;
  logic               in_run;
  logic               ev_mem, ev_mon, ev_halt, ev_tmo, ev_stall;

  commit_popcount #(
    .CHANNELS (CHANNELS),
    .POP_W    (POP_W)
  ) u_popcount (
    .commit (commit),
    .count  (pop)
  );

  // Inputs are masked during the first cycle out of reset (armed_q low).
  assign in_run  = (state_q == ST_RUN);
  assign ev_mem  = in_run && armed_q && mem_error;
  assign ev_mon  = in_run && armed_q && mon_error;
  assign ev_halt = in_run && armed_q && (|halt);
  assign ev_tmo  = in_run && (timeout_cycles != '0) &&
                   (cycle_count_q == timeout_cycles - CNT_W'(1));

`ifdef RUN_CTRL_STALL_WDOG_EN
  localparam int SW = $clog2(STALL_LIMIT + 1);

  logic [SW-1:0] stall_cnt_q;
  logic          commit_seen;

  assign commit_seen = armed_q && (|commit);
  assign ev_stall    = in_run && !commit_seen &&
                       (stall_cnt_q == SW'(STALL_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (in_run) begin
      stall_cnt_q <= commit_seen ? '0 : stall_cnt_q + SW'(1);
    end
  end
`else
  assign ev_stall = 1'b0;
`endif

  always_comb begin
    halt_low = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (halt[i]) halt_low = HC_W'(i);
    end
  end

  always_comb begin
    win = RSN_NONE;
    if (ev_mem)        win = RSN_MEM_ERR;
    else if (ev_mon)   win = RSN_MON_ERR;
    else if (ev_halt)  win = RSN_HALT;
    else if (ev_tmo)   win = RSN_TIMEOUT;
    else if (ev_stall) win = RSN_STALL;
  end

  always_comb begin
    state_d     = state_q;
    reason_d    = reason_q;
    finish_d    = finish_q;
    fail_d      = fail_q;
    halt_chan_d = halt_chan_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (win == RSN_HALT || win == RSN_TIMEOUT) begin
          state_d  = ST_DONE;
          reason_d = win;
          finish_d = 1'b1;
          fail_d   = (win != RSN_HALT);
          if (win == RSN_HALT) halt_chan_d = halt_low;
        end else if (win != RSN_NONE) begin
          reason_d = win;
          if (DRAIN_CYCLES == 0) begin
            state_d  = ST_DONE;
            finish_d = 1'b1;
            fail_d   = 1'b1;
          end else begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d  = ST_DONE;
          finish_d = 1'b1;
          fail_d   = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        end
      end
      ST_DONE: ;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      reason_q       <= RSN_NONE;
      finish_q       <= 1'b0;
      fail_q         <= 1'b0;
      halt_chan_q    <= '0;
      drain_cnt_q    <= '0;
      cycle_count_q  <= '0;
      commit_count_q <= '0;
      armed_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      reason_q    <= reason_d;
      finish_q    <= finish_d;
      fail_q      <= fail_d;
      halt_chan_q <= halt_chan_d;
      drain_cnt_q <= drain_cnt_d;
      armed_q     <= 1'b1;
      if (state_q != ST_DONE) begin
        cycle_count_q <= cycle_count_q + CNT_W'(1);
        if (armed_q) commit_count_q <= commit_count_q + CNT_W'(pop);
      end
    end
  end

  assign state        = state_q;
  assign reason       = reason_q;
  assign finish       = finish_q;
  assign fail         = fail_q;
  assign halt_chan    = halt_chan_q;
  assign cycle_count  = cycle_count_q;
  assign commit_count = commit_count_q;

endmodule

// File: doc/sim_run_ctrl.md
SIM_RUN_CTRL -- requirements
Module: sim_run_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 8: number of halt/commit monitor channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 64: width of cycle and commit counters.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 5: cycles spent in DRAIN after an error, before DONE.
REQ-004 SHALL have parameter STALL_LIMIT, default 100000: consecutive commit-free RUN cycles that trigger a stall.
REQ-005 SHALL have port clk  in  1: single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  in  1: asynchronous active-low reset.
REQ-007 SHALL have port halt  in  CHANNELS: per-channel halt request.
REQ-008 SHALL have port commit  in  CHANNELS: per-channel retire strobe.
REQ-009 SHALL have port mon_error  in  1: monitor-reported error.
REQ-010 SHALL have port mem_error  in  1: memory-model-reported error.
REQ-011 SHALL have port timeout_cycles  in  CNT_W: RUN-cycle budget, 0 = unlimited; quasi-static.
REQ-012 SHALL have port state  out  2: RUN=0, DRAIN=1, DONE=2.
REQ-013 SHALL have port finish  out  1: high while in DONE.
REQ-014 SHALL have port fail  out  1: high in DONE when reason is not HALT.
REQ-015 SHALL have port reason  out  3: NONE=0, HALT=1, TIMEOUT=2, MON_ERR=3, MEM_ERR=4, STALL=5.
REQ-016 SHALL have port halt_chan  out  $clog2(CHANNELS) (min 1): lowest-index halting channel.
REQ-017 SHALL have ports cycle_count and commit_count  out  CNT_W: RUN+DRAIN cycles elapsed; total commit bits retired.

Function
REQ-018 SHALL count cycle_count +1 every cycle in RUN or DRAIN and freeze it in DONE.
REQ-019 SHALL add popcount(commit) to commit_count every cycle in RUN or DRAIN and freeze it in DONE; counter wraps modulo 2^CNT_W.
REQ-020 SHALL evaluate terminating events each RUN cycle with priority MEM_ERR > MON_ERR > HALT > TIMEOUT > STALL; only the winner is latched into reason.
REQ-021 SHALL go RUN->DONE on the next edge for HALT, latching the lowest set index of halt into halt_chan.
REQ-022 SHALL go RUN->DONE on the next edge for TIMEOUT, asserted when timeout_cycles!=0 and cycle_count==timeout_cycles-1.
REQ-023 SHALL go RUN->DRAIN on MEM_ERR, MON_ERR or STALL and load a drain counter with DRAIN_CYCLES-1.
REQ-024 SHALL, in DRAIN, decrement the drain counter each cycle, enter DONE when the counter is 0 and the drain cycle is counted, ignore all inputs, and keep reason unchanged.
REQ-025 SHALL, with DRAIN_CYCLES==0, go RUN->DONE directly on error.
REQ-026 SHALL hold DONE until reset; finish and fail are registered and become valid in the first DONE cycle.
REQ-027 SHALL reset a stall counter on any commit bit set and increment it otherwise in RUN; STALL fires when it reaches STALL_LIMIT-1 with no commit that cycle.

Reset
REQ-028 SHALL, on rst_n low, immediately force state=RUN, finish=0, fail=0, reason=NONE, halt_chan=0, all counters=0, including mid-DRAIN or in DONE.
REQ-029 SHALL ignore halt, commit and errors in the first cycle after rst_n deasserts; cycle_count still increments.

Configuration
REQ-030 SHALL compile the stall watchdog (REQ-027, reason STALL) only when RUN_CTRL_STALL_WDOG_EN is defined; without it, no stall counter exists, STALL is never reported, and STALL_LIMIT is unused.

Structure
REQ-031 SHALL take the state and reason enums and their widths from shared package sim_run_pkg.
REQ-032 SHALL instantiate one sub-module, commit_popcount, parametrised by CHANNELS, that is combinational and returns popcount of commit.

Verification
REQ-033 SHALL cover: halt[5]=1 at cycle 100 -> DONE at cycle 101, reason=HALT, halt_chan=5, fail=0.
REQ-034 SHALL cover: timeout_cycles=50, no halt -> DONE after cycle_count=50, reason=TIMEOUT, fail=1.
REQ-035 SHALL cover: mem_error and halt[0] in the same cycle -> DRAIN for exactly 5 cycles, then DONE, reason=MEM_ERR.
REQ-036 SHALL cover: RUN_CTRL_STALL_WDOG_EN defined, STALL_LIMIT=20, commit=0 forever -> reason=STALL after 20 cycles plus drain; with the macro undefined -> no termination until timeout.
REQ-037 SHALL cover: commit=8'hFF for 10 cycles -> commit_count=80.
REQ-038 SHALL cover: rst_n pulsed low during DRAIN -> all outputs return to reset values asynchronously, and a new run starts cleanly.
